// File: rtl/vector_nor_gate.sv
// vector_nor_gate: element-wise NOR over a streamed vector, one registered result per A/B pair
module vector_nor_gate #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic                    DATA_A_IN_ENABLE,
    input  logic                    DATA_B_IN_ENABLE,
    output logic                    DATA_ENABLE,
    output logic                    DATA_OUT_ENABLE,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,
    input  logic [DATA_SIZE-1:0]    DATA_A_IN,
    input  logic [DATA_SIZE-1:0]    DATA_B_IN,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);
    typedef enum logic {STARTER_STATE, INPUT_STATE} state_t;
    state_t state, state_nxt;
    logic [CONTROL_SIZE-1:0] size_r, index_r;
    logic [DATA_SIZE-1:0] a_r, b_r, a_val, b_val;
    logic flag_a, flag_b, busy, pair, last, go, empty, ready_nxt, de_nxt;
    assign busy  = state == INPUT_STATE;
    assign go    = !busy && START;
    assign empty = SIZE_IN == '0;
    assign pair  = busy && (flag_a || DATA_A_IN_ENABLE) && (flag_b || DATA_B_IN_ENABLE);
    assign last  = index_r == size_r - CONTROL_SIZE'(1);
    assign a_val = DATA_A_IN_ENABLE ? DATA_A_IN : a_r;
    assign b_val = DATA_B_IN_ENABLE ? DATA_B_IN : b_r;
    // next state: leave idle on a non-empty start, return once the last pair completes
    always_comb
        state_nxt = busy ? ((pair && last) ? STARTER_STATE : INPUT_STATE)
                         : ((go && !empty) ? INPUT_STATE : STARTER_STATE);
    // pulse decisions for the following cycle
    always_comb begin
        ready_nxt = (go && empty) || (pair && last);
        de_nxt    = (go && !empty) || (pair && !last);
    end
    // state register
    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= STARTER_STATE;
        else     state <= state_nxt;
    // operand capture, element index and registered outputs
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            READY           <= 1'b0;
            DATA_ENABLE     <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
            DATA_OUT        <= '0;
            size_r          <= '0;
            index_r         <= '0;
            a_r             <= '0;
            b_r             <= '0;
            flag_a          <= 1'b0;
            flag_b          <= 1'b0;
        end else begin
            READY           <= ready_nxt;
            DATA_ENABLE     <= de_nxt;
            DATA_OUT_ENABLE <= pair;
            if (pair) DATA_OUT <= ~(a_val | b_val);
            if (go) begin
                size_r  <= SIZE_IN;
                index_r <= '0;
            end else if (pair && !last) index_r <= index_r + CONTROL_SIZE'(1);
            if (busy && DATA_A_IN_ENABLE) a_r <= DATA_A_IN;
            if (busy && DATA_B_IN_ENABLE) b_r <= DATA_B_IN;
            flag_a <= busy && (flag_a || DATA_A_IN_ENABLE) && !pair;
            flag_b <= busy && (flag_b || DATA_B_IN_ENABLE) && !pair;
        end
endmodule
